// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, angle constants and sequencer state encoding for the CORDIC block.
package cordic_pkg;
  localparam int ANGLE_W = 19;
  localparam int FRAC_W = 16;
  localparam logic [ANGLE_W-1:0] PI = 19'h3243F;
  localparam logic [ANGLE_W-1:0] HALF_PI = 19'h1921F;
  localparam logic [ANGLE_W-1:0] K_INV = 19'h09B75;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/cordic_pre_rot.sv
// cordic_pre_rot: combinational quadrant pre-rotation extending convergence to the full +/-pi domain.
// Only built when CORDIC_QUAD_EXT_EN is defined.
`ifdef CORDIC_QUAD_EXT_EN
module cordic_pre_rot
  import cordic_pkg::*;
(
  input  logic               mode,
  input  logic [ANGLE_W-1:0] x_in,
  input  logic [ANGLE_W-1:0] y_in,
  input  logic [ANGLE_W-1:0] z_in,
  output logic [ANGLE_W-1:0] x_o,
  output logic [ANGLE_W-1:0] y_o,
  output logic [ANGLE_W-1:0] z_o
);
  logic z_hi, z_lo, flip;
  always_comb begin
    z_hi = $signed(z_in) > $signed(HALF_PI);
    z_lo = $signed(z_in) < -$signed(HALF_PI);
    flip = mode ? x_in[ANGLE_W-1] : (z_hi | z_lo);
    x_o = flip ? -x_in : x_in;
    y_o = flip ? -y_in : y_in;
    // vectoring picks the pi offset from the sign of y so z stays inside +/-pi
    z_o = !flip ? z_in
        : mode ? (y_in[ANGLE_W-1] ? z_in - PI : z_in + PI)
        : (z_hi ? z_in - PI : z_in + PI);
  end
endmodule
`endif

// File: rtl/cordic_seq.sv
// cordic_seq: iterative CORDIC sequencer, one micro-rotation per clock, driving an external atan LUT.
// CORDIC_QUAD_EXT_EN enables quadrant pre-rotation at load.
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int ITERS = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [ANGLE_W-1:0] x_in,
  input  logic [ANGLE_W-1:0] y_in,
  input  logic [ANGLE_W-1:0] z_in,
  output logic [3:0]         atan_stage,
  input  logic [ANGLE_W-1:0] atan_val,
  output logic               busy,
  output logic               done,
  output logic [ANGLE_W-1:0] x_out,
  output logic [ANGLE_W-1:0] y_out,
  output logic [ANGLE_W-1:0] z_out
);
  state_t state_q, state_d;
  logic [3:0] i_q, i_d;
  logic mode_q, mode_d;
  logic signed [ANGLE_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [ANGLE_W-1:0] x_sh, y_sh, x_n, y_n, z_n;
  logic [ANGLE_W-1:0] ld_x, ld_y, ld_z;
  logic d_pos, last;
`ifdef CORDIC_QUAD_EXT_EN
  cordic_pre_rot u_pre_rot (
    .mode(mode), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .x_o(ld_x), .y_o(ld_y), .z_o(ld_z)
  );
`else
  assign ld_x = x_in;
  assign ld_y = y_in;
  assign ld_z = z_in;
`endif
  always_comb begin
    d_pos = mode_q ? y_q[ANGLE_W-1] : ~z_q[ANGLE_W-1];
    x_sh = x_q >>> i_q;
    y_sh = y_q >>> i_q;
    x_n = d_pos ? x_q - y_sh : x_q + y_sh;
    y_n = d_pos ? y_q + x_sh : y_q - x_sh;
    z_n = d_pos ? z_q - atan_val : z_q + atan_val;
    last = i_q == 4'(ITERS - 1);
    state_d = state_q;
    i_d = i_q;
    mode_d = mode_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        i_d = 4'd0;
        mode_d = mode;
        x_d = ld_x;
        y_d = ld_y;
        z_d = ld_z;
      end
      RUN: begin
        // counter wraps to 0 on the last step so atan_stage reads 0 outside RUN
        state_d = last ? DONE : RUN;
        i_d = last ? 4'd0 : i_q + 4'd1;
        x_d = x_n;
        y_d = y_n;
        z_d = z_n;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q <= '0;
      mode_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      mode_q <= mode_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end
  assign atan_stage = i_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign x_out = x_q;
  assign y_out = y_q;
  assign z_out = z_q;
endmodule

// File: tb/tb_cordic_seq.sv
// tb_cordic_seq: directed self-checking bench for cordic_seq; supplies the atan LUT and a behavioural CORDIC model.
module tb_cordic_seq;
  import cordic_pkg::*;
  localparam int ITERS = 12;
  localparam int TOL = 40;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
  logic [18:0] x_in = '0, y_in = '0, z_in = '0, atan_val;
  logic [3:0] atan_stage;
  logic busy, done;
  logic [18:0] x_out, y_out, z_out;
  int checks = 0, errors = 0;

  cordic_seq #(.ITERS(ITERS)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .atan_stage(atan_stage), .atan_val(atan_val),
    .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] lut(input logic [3:0] s);
    case (s)
      4'd0: return 19'd51472;
      4'd1: return 19'd30385;
      4'd2: return 19'd16055;
      4'd3: return 19'd8150;
      4'd4: return 19'd4091;
      4'd5: return 19'd2047;
      4'd6: return 19'd1024;
      4'd7: return 19'd512;
      4'd8: return 19'd256;
      4'd9: return 19'd128;
      4'd10: return 19'd64;
      4'd11: return 19'd32;
      default: return 19'd0;
    endcase
  endfunction

  assign atan_val = lut(atan_stage);

  function automatic int adiff(input logic [18:0] a, input logic [18:0] b);
    logic signed [18:0] d;
    d = a - b;
    return (d < 0) ? -int'(d) : int'(d);
  endfunction

  function automatic void ref_run(input logic m, input logic [18:0] xi, input logic [18:0] yi,
                                  input logic [18:0] zi, output logic [18:0] xo,
                                  output logic [18:0] yo, output logic [18:0] zo);
    logic signed [18:0] x, y, z, xs, ys;
    logic dp;
    x = xi; y = yi; z = zi;
`ifdef CORDIC_QUAD_EXT_EN
    if (!m && z > $signed(HALF_PI)) begin x = -x; y = -y; z = z - PI; end
    else if (!m && z < -$signed(HALF_PI)) begin x = -x; y = -y; z = z + PI; end
    else if (m && x < 0) begin z = (y >= 0) ? z + PI : z - PI; x = -x; y = -y; end
`endif
    for (int k = 0; k < ITERS; k++) begin
      dp = m ? (y < 0) : (z >= 0);
      xs = x >>> k;
      ys = y >>> k;
      x = dp ? x - ys : x + ys;
      y = dp ? y + xs : y - xs;
      z = dp ? z - lut(4'(k)) : z + lut(4'(k));
    end
    xo = x; yo = y; zo = z;
  endfunction

  task automatic do_op(input string tag, input logic m, input logic [18:0] xi,
                       input logic [18:0] yi, input logic [18:0] zi);
    logic [18:0] ex, ey, ez;
    logic [3:0] es;
    @(negedge clk);
    mode = m; x_in = xi; y_in = yi; z_in = zi; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= ITERS + 2; c++) begin
      @(negedge clk);
      es = (c <= ITERS) ? 4'(c - 1) : 4'd0;
      checks += 3;
      if (busy !== (c <= ITERS + 1)) begin
        errors++; $display("FAIL %s busy cycle %0d got %b exp %b", tag, c, busy, c <= ITERS + 1);
      end
      if (done !== (c == ITERS + 1)) begin
        errors++; $display("FAIL %s done cycle %0d got %b exp %b", tag, c, done, c == ITERS + 1);
      end
      if (atan_stage !== es) begin
        errors++; $display("FAIL %s atan_stage cycle %0d got %0d exp %0d", tag, c, atan_stage, es);
      end
    end
    ref_run(m, xi, yi, zi, ex, ey, ez);
    checks += 3;
    if (x_out !== ex) begin errors++; $display("FAIL %s x_out got %h exp %h", tag, x_out, ex); end
    if (y_out !== ey) begin errors++; $display("FAIL %s y_out got %h exp %h", tag, y_out, ey); end
    if (z_out !== ez) begin errors++; $display("FAIL %s z_out got %h exp %h", tag, z_out, ez); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    repeat (2) @(negedge clk);
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b exp 0", done); end
    if (atan_stage !== 4'd0) begin errors++; $display("FAIL reset atan_stage got %0d exp 0", atan_stage); end
    if (x_out !== 19'd0) begin errors++; $display("FAIL reset x_out got %h exp 0", x_out); end
    if (y_out !== 19'd0) begin errors++; $display("FAIL reset y_out got %h exp 0", y_out); end
    if (z_out !== 19'd0) begin errors++; $display("FAIL reset z_out got %h exp 0", z_out); end
    rst = 1'b0;
  endtask

  task automatic test_rotation;
    do_op("rot_pi4", 1'b0, 19'h09B75, 19'h0, 19'h0C910);
    checks += 3;
    if (adiff(x_out, 19'h0B505) > TOL) begin errors++; $display("FAIL rot_pi4 cos got %h exp ~0B505", x_out); end
    if (adiff(y_out, 19'h0B505) > TOL) begin errors++; $display("FAIL rot_pi4 sin got %h exp ~0B505", y_out); end
    if (adiff(z_out, 19'h0) > TOL) begin errors++; $display("FAIL rot_pi4 z got %h exp ~0", z_out); end
    do_op("rot_mpi4", 1'b0, 19'h09B75, 19'h0, 19'h736F0);
    checks += 2;
    if (adiff(x_out, 19'h0B505) > TOL) begin errors++; $display("FAIL rot_mpi4 cos got %h exp ~0B505", x_out); end
    if (adiff(y_out, 19'h74AFB) > TOL) begin errors++; $display("FAIL rot_mpi4 sin got %h exp ~74AFB", y_out); end
    do_op("rot_zero", 1'b0, 19'h09B75, 19'h0, 19'h0);
    checks += 2;
    if (adiff(x_out, 19'h10000) > TOL) begin errors++; $display("FAIL rot_zero cos got %h exp ~10000", x_out); end
    if (adiff(y_out, 19'h0) > TOL) begin errors++; $display("FAIL rot_zero sin got %h exp ~0", y_out); end
    do_op("rot_edge", 1'b0, 19'h09B75, 19'h0, 19'h1BE4A);
  endtask

  task automatic test_vectoring;
    do_op("vec_45", 1'b1, 19'h10000, 19'h10000, 19'h0);
    checks += 3;
    if (adiff(z_out, 19'h0C910) > TOL) begin errors++; $display("FAIL vec_45 angle got %h exp ~0C910", z_out); end
    if (adiff(x_out, 19'h25432) > TOL) begin errors++; $display("FAIL vec_45 mag got %h exp ~25432", x_out); end
    if (adiff(y_out, 19'h0) > TOL) begin errors++; $display("FAIL vec_45 y got %h exp ~0", y_out); end
    do_op("vec_neg", 1'b1, 19'h10000, 19'h70000, 19'h0);
    checks += 1;
    if (adiff(z_out, 19'h736F0) > TOL) begin errors++; $display("FAIL vec_neg angle got %h exp ~736F0", z_out); end
  endtask

  task automatic test_back_to_back;
    logic [18:0] ex, ey, ez;
    ref_run(1'b0, 19'h09B75, 19'h0, 19'h0C910, ex, ey, ez);
    @(negedge clk);
    mode = 1'b0; x_in = 19'h09B75; y_in = 19'h0; z_in = 19'h0C910; start = 1'b1;
    for (int c = 1; c <= 3 * (ITERS + 2) - 1; c++) begin
      @(negedge clk);
      if (c == 3 * (ITERS + 2) - 1) start = 1'b0;
      checks += 2;
      if (busy !== ((c % (ITERS + 2)) != 0)) begin
        errors++; $display("FAIL b2b busy cycle %0d got %b", c, busy);
      end
      if (done !== ((c % (ITERS + 2)) == ITERS + 1)) begin
        errors++; $display("FAIL b2b done cycle %0d got %b", c, done);
      end
      if ((c % (ITERS + 2)) == ITERS + 1) begin
        checks += 3;
        if (x_out !== ex) begin errors++; $display("FAIL b2b x_out cycle %0d got %h exp %h", c, x_out, ex); end
        if (y_out !== ey) begin errors++; $display("FAIL b2b y_out cycle %0d got %h exp %h", c, y_out, ey); end
        if (z_out !== ez) begin errors++; $display("FAIL b2b z_out cycle %0d got %h exp %h", c, z_out, ez); end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b idle after release got %b exp 0", busy); end
  endtask

  task automatic test_ignore_start;
    logic [18:0] ex, ey, ez;
    ref_run(1'b1, 19'h10000, 19'h10000, 19'h0, ex, ey, ez);
    @(negedge clk);
    mode = 1'b1; x_in = 19'h10000; y_in = 19'h10000; z_in = 19'h0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= ITERS + 3; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 7 || c == ITERS + 1);
      mode = 1'b0; x_in = 19'h05555; y_in = 19'h12345; z_in = 19'h01111;
      checks += 2;
      if (busy !== (c <= ITERS + 1)) begin errors++; $display("FAIL ign busy cycle %0d got %b", c, busy); end
      if (done !== (c == ITERS + 1)) begin errors++; $display("FAIL ign done cycle %0d got %b", c, done); end
    end
    checks += 3;
    if (x_out !== ex) begin errors++; $display("FAIL ign x_out got %h exp %h", x_out, ex); end
    if (y_out !== ey) begin errors++; $display("FAIL ign y_out got %h exp %h", y_out, ey); end
    if (z_out !== ez) begin errors++; $display("FAIL ign z_out got %h exp %h", z_out, ez); end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    mode = 1'b0; x_in = 19'h09B75; y_in = 19'h0; z_in = 19'h0C910; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy got %b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL midrst done got %b exp 0", done); end
    if (atan_stage !== 4'd0) begin errors++; $display("FAIL midrst atan_stage got %0d exp 0", atan_stage); end
    if (x_out !== 19'd0) begin errors++; $display("FAIL midrst x_out got %h exp 0", x_out); end
    if (y_out !== 19'd0) begin errors++; $display("FAIL midrst y_out got %h exp 0", y_out); end
    if (z_out !== 19'd0) begin errors++; $display("FAIL midrst z_out got %h exp 0", z_out); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midrst held done got %b exp 0", done); end
    rst = 1'b0;
    do_op("after_rst", 1'b1, 19'h10000, 19'h10000, 19'h0);
  endtask

  task automatic test_quad;
    do_op("quad_pi", 1'b0, 19'h09B75, 19'h0, 19'h3243F);
`ifdef CORDIC_QUAD_EXT_EN
    checks += 2;
    if (adiff(x_out, 19'h70000) > TOL) begin errors++; $display("FAIL quad_pi cos got %h exp ~70000", x_out); end
    if (adiff(y_out, 19'h0) > TOL) begin errors++; $display("FAIL quad_pi sin got %h exp ~0", y_out); end
    do_op("quad_vec", 1'b1, 19'h70000, 19'h10000, 19'h0);
    checks++;
    if (adiff(z_out, 19'h25B2F) > TOL) begin errors++; $display("FAIL quad_vec angle got %h exp ~25B2F", z_out); end
`endif
  endtask

  initial begin
    test_reset;
    test_rotation;
    test_vectoring;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid_run;
    test_quad;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
